// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : R-type issue front end for a registered ALU. Decodes the
//            instruction, reads operands from a 32x32 register file, drives
//            the ALU and writes its result back to rd.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int          NREGS  = 32,
  parameter logic [31:0] RSTVAL = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  alu_func,
  output logic [4:0]  alu_shiftamt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err_illegal,
  output logic        err_divzero,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] regs [0:NREGS-1];
  logic [4:0]  rd_q;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        funct_ok;
  logic [5:0]  func_code;
  logic        accept;
  logic        illegal;
  logic        divzero;
  logic        issue;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];

  // Register 0 is hardwired to zero on every read port.
  assign rs_val    = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val    = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];

  // Translate funct into the ALU operation code.
  always_comb begin
    funct_ok  = 1'b1;
    func_code = 6'd0;
    case (funct)
      FN_ADD:  func_code = 6'd0;
      FN_SUB:  func_code = 6'd1;
      FN_DIV:  func_code = 6'd2;
      FN_MULT: func_code = 6'd3;
      FN_SRL:  func_code = 6'd4;
      FN_SLL:  func_code = 6'd5;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Rejections take priority over issue; divide-by-zero only applies to legal div.
  assign accept  = instr_valid & instr_ready;
  assign illegal = accept & ((op != 6'd0) | ~funct_ok);
  assign divzero = accept & ~illegal & (funct == FN_DIV) & (rt_val == 32'd0);
  assign issue   = accept & ~illegal & ~divzero;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept -> ISSUE -> WB -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (issue) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE and never while reset is asserted.
  always_comb begin
    instr_ready = (state == S_IDLE) && !rst;
  end

  // ALU operand registers, latched destination and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_func     <= 6'd0;
      alu_shiftamt <= 5'd0;
      alu_a        <= 32'd0;
      alu_b        <= 32'd0;
      rd_q         <= 5'd0;
      wb_valid     <= 1'b0;
      wb_addr      <= 5'd0;
      wb_data      <= 32'd0;
      err_illegal  <= 1'b0;
      err_divzero  <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      err_illegal <= illegal;
      err_divzero <= divzero;
      if (issue) begin
        alu_func     <= func_code;
        alu_shiftamt <= shamt;
        alu_a        <= rs_val;
        alu_b        <= rt_val;
        rd_q         <= rd;
      end
      if (state == S_WB) begin
        wb_valid <= 1'b1;
        wb_addr  <= rd_q;
        wb_data  <= alu_result;
      end
    end
  end

  // Register file: writeback at the end of WB; writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RSTVAL;
    end else if ((state == S_WB) && (rd_q != 5'd0)) begin
      regs[rd_q] <= alu_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Directed self-checking bench for alu_issue_ctrl with a small
//            registered ALU model closing the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  alu_func;
  logic [4:0]  alu_shiftamt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err_illegal;
  logic        err_divzero;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  int checks = 0;
  int errors = 0;

  // Seeding hook: when set, the ALU model returns ovr_val instead of computing.
  logic        ovr_en;
  logic [31:0] ovr_val;

  alu_issue_ctrl #(.NREGS(32), .RSTVAL(32'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_func     (alu_func),
    .alu_shiftamt (alu_shiftamt),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .err_illegal  (err_illegal),
    .err_divzero  (err_divzero),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU model, one cycle latency, shares reset.
  always @(posedge clk) begin
    if (rst) alu_result <= 32'd0;
    else if (ovr_en) alu_result <= ovr_val;
    else begin
      case (alu_func)
        6'd0:    alu_result <= alu_a + alu_b;
        6'd1:    alu_result <= alu_a - alu_b;
        6'd2:    alu_result <= (alu_b != 0) ? alu_a / alu_b : 32'd0;
        6'd3:    alu_result <= alu_a * alu_b;
        6'd4:    alu_result <= alu_b >> alu_shiftamt;
        6'd5:    alu_result <= alu_b << alu_shiftamt;
        default: alu_result <= 32'd0;
      endcase
    end
  end

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  // Present one instruction, accept it, and check the writeback two edges later.
  task automatic do_op(input string tag, input logic [31:0] w,
                       input logic [4:0] exp_addr, input logic [31:0] exp_data);
    instr = w;
    instr_valid = 1'b1;
    check({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check({tag, "_wb_c1"}, {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_wb_c2"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, exp_addr});
    check({tag, "_wb_data"}, wb_data, exp_data);
  endtask

  // Present one instruction expected to be rejected with a pulse.
  task automatic do_reject(input string tag, input logic [31:0] w,
                           input logic exp_ill, input logic exp_dz);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check({tag, "_illegal"}, {31'd0, err_illegal}, {31'd0, exp_ill});
    check({tag, "_divzero"}, {31'd0, err_divzero}, {31'd0, exp_dz});
    check({tag, "_no_wb"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, {30'd0, err_illegal, err_divzero}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    dbg_raddr = 5'd0;
    ovr_en = 1'b0;
    ovr_val = 32'd0;

    // Reset behaviour.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ready_in_rst", {31'd0, instr_ready}, 32'd0);
    check("alu_func_rst", {26'd0, alu_func}, 32'd0);
    check("alu_a_rst", alu_a, 32'd0);
    check("wb_valid_rst", {31'd0, wb_valid}, 32'd0);
    check("err_rst", {30'd0, err_illegal, err_divzero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 32; i++) check_dbg("dbg_rst", i[4:0], 32'd0);

    // Seed R1=7 and R2=5 through adds whose ALU result is forced.
    ovr_en = 1'b1; ovr_val = 32'd7;
    do_op("seed_r1", rtype(6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20), 5'd1, 32'd7);
    ovr_val = 32'd5;
    do_op("seed_r2", rtype(6'd0, 5'd0, 5'd0, 5'd2, 5'd0, 6'h20), 5'd2, 32'd5);
    ovr_en = 1'b0;
    check_dbg("dbg_r1", 5'd1, 32'd7);
    check_dbg("dbg_r2", 5'd2, 32'd5);

    // sub r3 = r1 - r2, check the issued ALU fields in the ISSUE cycle.
    instr = rtype(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("sub_func", {26'd0, alu_func}, 32'd1);
    check("sub_a", alu_a, 32'd7);
    check("sub_b", alu_b, 32'd5);
    @(posedge clk); #1;
    check("sub_wb_early", {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    check("sub_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("sub_wb_addr", {27'd0, wb_addr}, 32'd3);
    check("sub_wb_data", wb_data, 32'd2);
    check_dbg("dbg_r3", 5'd3, 32'd2);

    // sll r4 = r2 << 3; srl r5 = r4 >> 2.
    instr = rtype(6'd0, 5'd9, 5'd2, 5'd4, 5'd3, 6'h00);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("sll_func", {26'd0, alu_func}, 32'd5);
    check("sll_shamt", {27'd0, alu_shiftamt}, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sll_wb_data", wb_data, 32'd40);
    check("sll_wb_addr", {27'd0, wb_addr}, 32'd4);
    do_op("srl", rtype(6'd0, 5'd0, 5'd4, 5'd5, 5'd2, 6'h02), 5'd5, 32'd10);
    check("srl_func_hold", {26'd0, alu_func}, 32'd4);

    // Rejections: divide by zero (R6=0), illegal opcode, unsupported funct.
    do_reject("divzero", rtype(6'd0, 5'd1, 5'd6, 5'd7, 5'd0, 6'h1A), 1'b0, 1'b1);
    check_dbg("dbg_r7_untouched", 5'd7, 32'd0);
    check("divzero_alu_hold", {26'd0, alu_func}, 32'd4);
    do_reject("bad_op", rtype(6'h23, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20), 1'b1, 1'b0);
    do_reject("bad_funct", rtype(6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h21), 1'b1, 1'b0);
    check_dbg("dbg_r8_untouched", 5'd8, 32'd0);

    // Legal div with nonzero divisor: r11 = r4 / r2 = 8.
    do_op("div", rtype(6'd0, 5'd4, 5'd2, 5'd11, 5'd0, 6'h1A), 5'd11, 32'd8);
    // mult: r12 = r1 * r2 = 35.
    do_op("mult", rtype(6'd0, 5'd1, 5'd2, 5'd12, 5'd0, 6'h18), 5'd12, 32'd35);

    // add to r0: writeback reported but register stays zero.
    do_op("add_r0", rtype(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 5'd0, 32'd12);
    check_dbg("dbg_r0", 5'd0, 32'd0);

    // Back-to-back with instr_valid held high.
    instr = rtype(6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20);   // r8 = 7+5
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = rtype(6'd0, 5'd8, 5'd1, 5'd9, 5'd0, 6'h20);   // r9 = r8+7
    @(posedge clk); #1;
    check("b2b_hold_a", alu_a, 32'd7);
    @(posedge clk); #1;
    check("b2b_wb1_valid", {31'd0, wb_valid}, 32'd1);
    check("b2b_wb1_data", wb_data, 32'd12);
    check("b2b_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    check("b2b_wb1_end", {31'd0, wb_valid}, 32'd0);
    check("b2b_second_a", alu_a, 32'd12);
    check("b2b_second_b", alu_b, 32'd7);
    instr = rtype(6'd0, 5'd9, 5'd1, 5'd10, 5'd0, 6'h22); // r10 = r9-7
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_wb2_valid", {31'd0, wb_valid}, 32'd1);
    check("b2b_wb2_addr", {27'd0, wb_addr}, 32'd9);
    check("b2b_wb2_data", wb_data, 32'd19);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("third_a", alu_a, 32'd19);

    // Reset during ISSUE of the third instruction.
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", {31'd0, instr_ready}, 32'd0);
    check("abort_alu_func", {26'd0, alu_func}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    check("abort_ready_back", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 32; i++) check_dbg("dbg_after_abort", i[4:0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
